// File: rtl/ppc_cmd_controller_pkg.sv
// Shared encodings for the ping-pong counter command controller.
// Command codes and controller FSM states.
package ppc_cmd_controller_pkg;

  typedef enum logic [1:0] {
    CMD_RUN  = 2'd0,
    CMD_STOP = 2'd1,
    CMD_FLIP = 2'd2,
    CMD_CFG  = 2'd3
  } cmd_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_EXEC  = 2'd1,
    S_APPLY = 2'd2,
    S_RESP  = 2'd3
  } state_e;

endpackage

// File: rtl/ppc_cmd_controller_if.sv
// Requester, response and counter-control bundle for ppc_cmd_controller.
// master = requesters plus counter side, slave = controller.
interface ppc_cmd_controller_if
  import ppc_cmd_controller_pkg::*;
#(
  parameter int WIDTH = 4
);
  logic             req0_valid;
  cmd_e             req0_cmd;
  logic [WIDTH-1:0] req0_max;
  logic [WIDTH-1:0] req0_min;
  logic             req0_ready;
  logic             req1_valid;
  cmd_e             req1_cmd;
  logic [WIDTH-1:0] req1_max;
  logic [WIDTH-1:0] req1_min;
  logic             req1_ready;
  logic             rsp_valid;
  logic             rsp_id;
  logic             rsp_err;
  logic [WIDTH-1:0] ctr_out;
  logic             ctr_dir;
  logic             ctr_enable;
  logic             ctr_flip;
  logic [WIDTH-1:0] ctr_max;
  logic [WIDTH-1:0] ctr_min;
  logic             ctr_load;

  modport master (
    output req0_valid, req0_cmd, req0_max, req0_min,
    input  req0_ready,
    output req1_valid, req1_cmd, req1_max, req1_min,
    input  req1_ready,
    input  rsp_valid, rsp_id, rsp_err,
    output ctr_out, ctr_dir,
    input  ctr_enable, ctr_flip, ctr_max, ctr_min, ctr_load
  );

  modport slave (
    input  req0_valid, req0_cmd, req0_max, req0_min,
    output req0_ready,
    input  req1_valid, req1_cmd, req1_max, req1_min,
    output req1_ready,
    output rsp_valid, rsp_id, rsp_err,
    input  ctr_out, ctr_dir,
    output ctr_enable, ctr_flip, ctr_max, ctr_min, ctr_load
  );
endinterface

// File: rtl/ppc_cmd_controller_rr_arb2.sv
// Two-way round-robin arbiter; the tie pointer moves
// only when a granted request is actually transferred.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] valid,
  input  logic       advance,
  output logic [1:0] grant
);
  logic ptr;

  always_comb begin
    grant = valid;
    if (valid == 2'b11)
      grant = ptr ? 2'b10 : 2'b01;
  end

  // after serving req0 the tie goes to req1, and vice versa
  always_ff @(posedge clk) begin
    if (rst)
      ptr <= 1'b0;
    else if (advance)
      ptr <= grant[0];
  end
endmodule

// File: rtl/ppc_cmd_controller.sv
// Arbitrates two command requesters and sequences each command
// into registered ping-pong counter controls with a response pulse.
module ppc_cmd_controller
  import ppc_cmd_controller_pkg::*;
#(
  parameter int WIDTH         = 4,
  parameter int DEF_MAX       = 15,
  parameter int DEF_MIN       = 0,
  parameter int RUN_AFTER_RST = 1
) (
  input logic                 clk,
  input logic                 rst,
  ppc_cmd_controller_if.slave bus
);
  state_e           state, state_nx;
  logic [1:0]       grant;
  logic             accept, sel;
  cmd_e             in_cmd;
  logic [WIDTH-1:0] in_max, in_min;
  logic             in_err, cfg_go;

  logic             id_q, err_q, cfg_q, en_save;
  logic [WIDTH-1:0] max_q, min_q;

  logic             en_r, flip_r, load_r;
  logic [WIDTH-1:0] max_r, min_r;
  logic             rv_r, rid_r, rerr_r;
  logic             en_nx, flip_nx, load_nx;
  logic [WIDTH-1:0] max_nx, min_nx;
  logic             rv_nx, rid_nx, rerr_nx;

  logic unused_status;
  assign unused_status = ^{bus.ctr_out, bus.ctr_dir};

  rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .valid   ({bus.req1_valid, bus.req0_valid}),
    .advance (accept),
    .grant   (grant)
  );

  assign bus.req0_ready = (state == S_IDLE) && !rst && grant[0];
  assign bus.req1_ready = (state == S_IDLE) && !rst && grant[1];
  assign accept = bus.req0_ready | bus.req1_ready;

  assign sel    = grant[1];
  assign in_cmd = sel ? bus.req1_cmd : bus.req0_cmd;
  assign in_max = sel ? bus.req1_max : bus.req0_max;
  assign in_min = sel ? bus.req1_min : bus.req0_min;
  assign cfg_go = (in_cmd == CMD_CFG) && (in_max > in_min);
  assign in_err = ((in_cmd == CMD_FLIP) && !en_r)
               || ((in_cmd == CMD_CFG) && !cfg_go);

  always_ff @(posedge clk) begin
    if (rst)
      state <= S_IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  if (accept) state_nx = S_EXEC;
      S_EXEC:  state_nx = cfg_q ? S_APPLY : S_RESP;
      S_APPLY: state_nx = S_RESP;
      S_RESP:  state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    en_nx   = en_r;
    flip_nx = 1'b0;
    load_nx = 1'b0;
    max_nx  = max_r;
    min_nx  = min_r;
    rv_nx   = 1'b0;
    rid_nx  = 1'b0;
    rerr_nx = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (accept) begin
          unique case (1'b1)
            in_cmd == CMD_RUN:  en_nx = 1'b1;
            in_cmd == CMD_STOP: en_nx = 1'b0;
            in_cmd == CMD_FLIP: flip_nx = en_r;
            in_cmd == CMD_CFG:  if (cfg_go) en_nx = 1'b0;
          endcase
        end
      end
      S_EXEC: begin
        if (cfg_q) begin
          max_nx  = max_q;
          min_nx  = min_q;
          load_nx = 1'b1;
        end else begin
          rv_nx   = 1'b1;
          rid_nx  = id_q;
          rerr_nx = err_q;
        end
      end
      S_APPLY: begin
        en_nx   = en_save;
        rv_nx   = 1'b1;
        rid_nx  = id_q;
        rerr_nx = err_q;
      end
      S_RESP: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      id_q    <= 1'b0;
      err_q   <= 1'b0;
      cfg_q   <= 1'b0;
      en_save <= 1'b0;
      max_q   <= '0;
      min_q   <= '0;
    end else if (accept) begin
      id_q    <= sel;
      err_q   <= in_err;
      cfg_q   <= cfg_go;
      en_save <= en_r;
      max_q   <= in_max;
      min_q   <= in_min;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      en_r   <= 1'(RUN_AFTER_RST);
      flip_r <= 1'b0;
      load_r <= 1'b0;
      max_r  <= WIDTH'(DEF_MAX);
      min_r  <= WIDTH'(DEF_MIN);
      rv_r   <= 1'b0;
      rid_r  <= 1'b0;
      rerr_r <= 1'b0;
    end else begin
      en_r   <= en_nx;
      flip_r <= flip_nx;
      load_r <= load_nx;
      max_r  <= max_nx;
      min_r  <= min_nx;
      rv_r   <= rv_nx;
      rid_r  <= rid_nx;
      rerr_r <= rerr_nx;
    end
  end

  assign bus.ctr_enable = en_r;
  assign bus.ctr_flip   = flip_r;
  assign bus.ctr_load   = load_r;
  assign bus.ctr_max    = max_r;
  assign bus.ctr_min    = min_r;
  assign bus.rsp_valid  = rv_r;
  assign bus.rsp_id     = rid_r;
  assign bus.rsp_err    = rerr_r;
endmodule

// File: tb/tb_ppc_cmd_controller.sv
// Bench for ppc_cmd_controller: directed scenarios plus random traffic,
// checked every cycle against a transaction-level timeline model.
module tb_ppc_cmd_controller;
  import ppc_cmd_controller_pkg::*;

  localparam int W = 4;
  localparam int EV_EN = 0, EV_CFG = 1, EV_FLIP = 2, EV_RSP = 3;

  typedef struct {
    int         at;
    int         kind;
    logic [3:0] a;
    logic [3:0] b;
    logic       c;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ppc_cmd_controller_if #(.WIDTH(W)) bus ();

  ppc_cmd_controller #(
    .WIDTH(W), .DEF_MAX(15), .DEF_MIN(0), .RUN_AFTER_RST(1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  bit chk_en = 0;
  bit do_rst = 0;

  logic       m_en, m_flip, m_load, m_rv, m_rid, m_rerr;
  logic [3:0] m_max, m_min;
  int         next_free;
  bit         last_gnt;
  ev_t        evq[$];

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got=%h expected=%h",
                  name, cyc, got, exp);
  endtask

  task automatic model_reset();
    m_en = 1'b1;
    m_max = 4'd15;
    m_min = 4'd0;
    evq.delete();
    last_gnt = 1'b1;
    next_free = cyc;
  endtask

  task automatic sched(input int at, input int kind, input logic [3:0] a,
                       input logic [3:0] b, input logic c);
    ev_t e;
    e.at = at; e.kind = kind; e.a = a; e.b = b; e.c = c;
    evq.push_back(e);
  endtask

  // Spec-level timeline: an accept at cycle n fixes what each later cycle shows
  task automatic model_accept(input bit id, input cmd_e c,
                              input logic [3:0] mx, input logic [3:0] mn);
    int n;
    n = cyc;
    last_gnt = id;
    next_free = n + 3;
    case (c)
      CMD_RUN: begin
        sched(n + 1, EV_EN, 0, 0, 1'b1);
        sched(n + 2, EV_RSP, 0, 0, 1'b0);
      end
      CMD_STOP: begin
        sched(n + 1, EV_EN, 0, 0, 1'b0);
        sched(n + 2, EV_RSP, 0, 0, 1'b0);
      end
      CMD_FLIP: begin
        if (m_en) sched(n + 1, EV_FLIP, 0, 0, 1'b1);
        sched(n + 2, EV_RSP, 0, 0, !m_en);
      end
      default: begin
        if (mx > mn) begin
          sched(n + 1, EV_EN, 0, 0, 1'b0);
          sched(n + 2, EV_CFG, mx, mn, 1'b1);
          sched(n + 3, EV_EN, 0, 0, m_en);
          sched(n + 3, EV_RSP, 0, 0, 1'b0);
          next_free = n + 4;
        end else begin
          sched(n + 2, EV_RSP, 0, 0, 1'b1);
        end
      end
    endcase
    for (int i = 0; i < evq.size(); i++)
      if (evq[i].kind == EV_RSP && evq[i].at > n) evq[i].a = {3'b0, id};
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      logic [15:0] got, exp;
      logic v0, v1, idle, win, er0, er1;
      cyc++;
      m_flip = 0; m_load = 0; m_rv = 0; m_rid = 0; m_rerr = 0;
      if (do_rst) begin
        model_reset();
        do_rst = 0;
      end
      for (int i = evq.size() - 1; i >= 0; i--) begin
        if (evq[i].at == cyc) begin
          case (evq[i].kind)
            EV_EN:   m_en = evq[i].c;
            EV_CFG:  begin m_max = evq[i].a; m_min = evq[i].b; m_load = 1; end
            EV_FLIP: m_flip = 1;
            default: begin m_rv = 1; m_rid = evq[i].a[0]; m_rerr = evq[i].c; end
          endcase
          evq.delete(i);
        end
      end
      v0 = bus.req0_valid;
      v1 = bus.req1_valid;
      idle = (cyc >= next_free) && !rst;
      win = (v0 && v1) ? !last_gnt : v1;
      er0 = idle && v0 && !win;
      er1 = idle && v1 && win;
      exp = {m_en, m_max, m_min, m_flip, m_load, m_rv,
             m_rv & m_rid, m_rv & m_rerr, er0, er1};
      got = {bus.ctr_enable, bus.ctr_max, bus.ctr_min, bus.ctr_flip,
             bus.ctr_load, bus.rsp_valid, bus.rsp_valid & bus.rsp_id,
             bus.rsp_valid & bus.rsp_err, bus.req0_ready, bus.req1_ready};
      check("cycle_model", 32'(got), 32'(exp));
      if (rst)
        do_rst = 1;
      else if (er0)
        model_accept(0, bus.req0_cmd, bus.req0_max, bus.req0_min);
      else if (er1)
        model_accept(1, bus.req1_cmd, bus.req1_max, bus.req1_min);
    end
  end

  always @(posedge clk) begin
    #1;
    bus.ctr_out = 4'($urandom);
    bus.ctr_dir = 1'($urandom);
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit id, input cmd_e c, input logic [3:0] mx,
                       input logic [3:0] mn);
    if (!id) begin
      bus.req0_valid = 1; bus.req0_cmd = c;
      bus.req0_max = mx;  bus.req0_min = mn;
    end else begin
      bus.req1_valid = 1; bus.req1_cmd = c;
      bus.req1_max = mx;  bus.req1_min = mn;
    end
  endtask

  task automatic send(input bit id, input cmd_e c, input logic [3:0] mx,
                      input logic [3:0] mn, output int t);
    bit ok;
    ok = 0;
    t = -1;
    drive(id, c, mx, mn);
    for (int k = 0; k < 20 && !ok; k++) begin
      step();
      if (id ? bus.req1_ready : bus.req0_ready) begin
        ok = 1;
        t = cyc;
      end
    end
    if (!ok) begin
      n_chk++;
      $display("FAIL send_timeout: requester %0d got no ready in 20 cycles", id);
    end
    edge1();
    if (!id) bus.req0_valid = 0; else bus.req1_valid = 0;
  endtask

  initial begin
    int t, t0, t1, nflip, nrsp;
    logic [1:0] ids;
    bit a0, a1;
    bus.req0_valid = 0; bus.req0_cmd = CMD_RUN; bus.req0_max = 0; bus.req0_min = 0;
    bus.req1_valid = 0; bus.req1_cmd = CMD_RUN; bus.req1_max = 0; bus.req1_min = 0;
    bus.ctr_out = 0; bus.ctr_dir = 0;
    rst = 1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1;
    edge1();
    rst = 0;

    step();
    check("rst_enable", 32'(bus.ctr_enable), 32'd1);
    check("rst_max", 32'(bus.ctr_max), 32'd15);
    check("rst_min", 32'(bus.ctr_min), 32'd0);
    check("rst_pulses", 32'({bus.ctr_flip, bus.ctr_load, bus.rsp_valid}), 32'd0);

    edge1();
    send(0, CMD_CFG, 4'd9, 4'd3, t);
    step();
    check("cfg_en_off", 32'(bus.ctr_enable), 32'd0);
    step();
    check("cfg_apply", 32'({bus.ctr_max, bus.ctr_min, bus.ctr_load}),
          32'({4'd9, 4'd3, 1'b1}));
    step();
    check("cfg_rsp", 32'({bus.ctr_enable, bus.rsp_valid, bus.rsp_id, bus.rsp_err}),
          32'b1100);

    edge1();
    send(1, CMD_CFG, 4'd5, 4'd5, t);
    step();
    step();
    check("badcfg_rsp", 32'({bus.rsp_valid, bus.rsp_id, bus.rsp_err, bus.ctr_load,
                             bus.ctr_max, bus.ctr_min}),
          32'({1'b1, 1'b1, 1'b1, 1'b0, 4'd9, 4'd3}));

    edge1();
    drive(0, CMD_FLIP, 0, 0);
    drive(1, CMD_FLIP, 0, 0);
    t0 = -1; t1 = -1; nflip = 0; nrsp = 0; ids = 2'b11;
    for (int k = 0; k < 12; k++) begin
      step();
      if (bus.req0_valid && bus.req0_ready) t0 = cyc;
      if (bus.req1_valid && bus.req1_ready) t1 = cyc;
      if (bus.ctr_flip) nflip++;
      if (bus.rsp_valid) begin
        if (nrsp < 2) ids[1 - nrsp] = bus.rsp_id;
        nrsp++;
      end
      edge1();
      if (t0 >= 0) bus.req0_valid = 0;
      if (t1 >= 0) bus.req1_valid = 0;
    end
    check("flip_req0_first", 32'(t1 - t0), 32'd3);
    check("flip_pulses", 32'(nflip), 32'd2);
    check("flip_rsp_count", 32'(nrsp), 32'd2);
    check("flip_rsp_ids", 32'(ids), 32'b01);

    send(0, CMD_STOP, 0, 0, t);
    step();
    check("stop_en", 32'(bus.ctr_enable), 32'd0);
    edge1();
    send(0, CMD_FLIP, 0, 0, t);
    step();
    check("stopflip_nopulse", 32'(bus.ctr_flip), 32'd0);
    step();
    check("stopflip_err", 32'({bus.rsp_valid, bus.rsp_err, bus.ctr_flip}), 32'b110);
    edge1();
    send(0, CMD_RUN, 0, 0, t);
    step();
    check("run_en", 32'(bus.ctr_enable), 32'd1);

    edge1();
    edge1();
    send(0, CMD_CFG, 4'd12, 4'd2, t);
    rst = 1;
    step();
    edge1();
    rst = 0;
    for (int k = 0; k < 4; k++) begin
      step();
      check("rst_midcfg", 32'({bus.ctr_enable, bus.ctr_max, bus.ctr_min,
                               bus.rsp_valid, bus.ctr_load}),
            32'({1'b1, 4'd15, 4'd0, 1'b0, 1'b0}));
    end

    edge1();
    for (int i = 0; i < 800; i++) begin
      step();
      a0 = bus.req0_valid && bus.req0_ready;
      a1 = bus.req1_valid && bus.req1_ready;
      edge1();
      if (rst) rst = 0;
      else if ($urandom_range(0, 79) == 0) rst = 1;
      if (a0) bus.req0_valid = 0;
      if (a1) bus.req1_valid = 0;
      if (!bus.req0_valid && $urandom_range(0, 2) == 0)
        drive(0, cmd_e'(2'($urandom_range(0, 3))), 4'($urandom), 4'($urandom));
      if (!bus.req1_valid && $urandom_range(0, 2) == 0)
        drive(1, cmd_e'(2'($urandom_range(0, 3))), 4'($urandom), 4'($urandom));
    end
    bus.req0_valid = 0;
    bus.req1_valid = 0;
    rst = 0;
    repeat (8) step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
